clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run-time controller for the board's clock-division resource. It accepts divisor and mode configurations over a valid/ready handshake and generates the divided clock in one of three modes: continuous, stopped or one-shot. Configuration changes that arrive while a waveform is in progress take effect only at a clean period boundary, so downstream logic (display scan, counters) never sees a runt pulse. A one-cycle tick strobe marks every output edge and serves as a clock enable for synchronous consumers.

Parameters:
WIDTH, 32, width of divisor and internal counter
DEFAULT_DIV, 50000000, half-period divisor loaded at reset (1 Hz from 100 MHz toggle rate)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  controller can accept a configuration
cfg_div  input  WIDTH  half-period length in clk cycles; valid range 1..2^WIDTH-1
cfg_mode  input  2  00 STOP, 01 RUN, 10 ONESHOT, 11 reserved
start  input  1  one-shot trigger, sampled only in ARMED
clk_div  output  1  divided clock, registered
tick  output  1  one-cycle pulse in the same cycle clk_div changes
busy  output  1  waveform active or configuration pending
cfg_err  output  1  sticky flag for an illegal configuration

Behaviour:
- The clock is clk; reset is asynchronous and active-low. Asserting reset at any time, including mid-period, immediately forces all outputs and state to reset values and discards any pending configuration.
- Reset values: state IDLE, div_q=DEFAULT_DIV, cnt=0, clk_div=0, tick=0, cfg_ready=1, busy=0, cfg_err=0, pend=0.
- States: IDLE (output held at 0), RUN (free-running square wave), ARMED (one-shot waiting for start, output 0), SHOT (one pulse in progress).
- Handshake: a transfer occurs when cfg_valid=1 and cfg_ready=1. cfg_ready = ~pend. At most one configuration is pending.
- Illegal configuration (cfg_div=0 or cfg_mode=11):
  - The handshake completes, the request is discarded and cfg_err is set.
  - cfg_err clears on the next legal transfer.
- Counting:
  - cnt increments each cycle in RUN and SHOT.
  - When cnt==div_q-1: cnt<=0, clk_div toggles and tick=1.
  - div_q=1 therefore toggles every cycle.
  - cnt and div_q are WIDTH bits and never wrap past div_q-1.
- Configuration in IDLE or ARMED: the transfer is applied in the next cycle. div_q<=cfg_div, cnt<=0, clk_div stays 0, and the next state is set by the mode:
  - STOP: IDLE.
  - RUN: RUN. The first rising edge comes div_q cycles after entry.
  - ONESHOT: ARMED.
- Configuration in RUN or SHOT:
  - The transfer is stored in pend_div/pend_mode and pend is set to 1.
  - It is applied at the next falling edge of clk_div: clk_div goes 1->0, tick=1, cnt<=0, div_q<=pend_div, pend<=0.
  - The state then follows pend_mode as above, and the new period starts low.
  - In RUN, a rising edge never triggers the apply.
- ONESHOT sequence:
  - In ARMED, start=1 moves the state to SHOT and sets clk_div=1 and tick=1 in the next cycle, with cnt=0.
  - clk_div stays high for div_q cycles, then falls (tick=1) and the state returns to ARMED, or applies the pending configuration.
  - start is ignored in IDLE, RUN and SHOT. Retriggering during SHOT is not supported.
- Simultaneous start and configuration transfer in ARMED: start wins. The configuration becomes pending and is applied at the end of the shot.
- busy = (state==RUN) | (state==SHOT) | pend.
- tick is never asserted in IDLE or ARMED, except on the cycle of the falling edge that enters them.

Test Plan:
- Reset, then configure RUN with div=3 -> after the handshake, clk_div rises 3 cycles later; period is 6 cycles; tick appears every 3 cycles, aligned with each edge; busy=1.
- In RUN with div=3, configure RUN with div=5 while clk_div=1 -> cfg_ready=0 until the falling edge; the old high phase completes as exactly 3 cycles; the following low phase is 5 cycles; cfg_ready returns to 1.
- Configure ONESHOT with div=4, pulse start -> clk_div is high for exactly 4 cycles starting the cycle after start; two ticks occur; the state returns to ARMED; a second start produces an identical pulse.
- Send cfg_div=0, then cfg_mode=11 -> both handshakes complete; state and div_q are unchanged; cfg_err=1; a following legal RUN/div=2 transfer clears cfg_err.
- In RUN with div=2, configure STOP -> clk_div ends low at the next falling edge; the state is IDLE; busy=0; no further ticks occur.
- Assert reset mid-high-phase with a configuration pending -> clk_div=0, tick=0 and cfg_ready=1 immediately (asynchronous); after release, the block is in IDLE with div_q=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time configurable clock divider with STOP / RUN / ONESHOT modes.
// Reconfiguration during an active waveform is deferred to the next falling edge of clk_div.
module clk_div_ctrl #(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic             start,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, ARMED, SHOT} state_e;

  localparam logic [1:0]       MODE_RUN     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [1:0]       MODE_RSVD    = 2'b11;
  localparam logic [WIDTH-1:0] DIV_RST      = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [1:0]       pend_mode_q, pend_mode_d;

  logic xfer, legal, wrap;

  assign xfer  = cfg_valid & ~pend_q;
  assign legal = (cfg_div != '0) && (cfg_mode != MODE_RSVD);
  assign wrap  = (cnt_q == div_q - ONE);

  function automatic state_e mode_state(input logic [1:0] mode);
    case (mode)
      MODE_RUN:     return RUN;
      MODE_ONESHOT: return ARMED;
      default:      return IDLE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  // Pending payload is qualified by pend_q, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_div_q  <= pend_div_d;
    pend_mode_q <= pend_mode_d;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    clk_div_d   = clk_div_q;
    tick_d      = 1'b0;
    pend_d      = pend_q;
    err_d       = err_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;

    if (xfer) err_d = ~legal;

    unique case (state_q)
      IDLE, ARMED: begin
        if (state_q == ARMED && start) begin
          // A start wins over a simultaneous configuration, which waits for the shot to end.
          state_d   = SHOT;
          clk_div_d = 1'b1;
          tick_d    = 1'b1;
          cnt_d     = '0;
          if (xfer && legal) begin
            pend_d      = 1'b1;
            pend_div_d  = cfg_div;
            pend_mode_d = cfg_mode;
          end
        end else if (xfer && legal) begin
          state_d   = mode_state(cfg_mode);
          div_d     = cfg_div;
          cnt_d     = '0;
          clk_div_d = 1'b0;
        end
      end
      RUN, SHOT: begin
        if (xfer && legal) begin
          pend_d      = 1'b1;
          pend_div_d  = cfg_div;
          pend_mode_d = cfg_mode;
        end
        if (wrap) begin
          cnt_d     = '0;
          clk_div_d = ~clk_div_q;
          tick_d    = 1'b1;
          // Only a falling edge may switch configuration, so no runt pulse is produced.
          if (clk_div_q) begin
            if (pend_q) begin
              div_d   = pend_div_q;
              pend_d  = 1'b0;
              state_d = mode_state(pend_mode_q);
            end else if (state_q == SHOT) begin
              state_d = ARMED;
            end
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_comb begin
    cfg_ready = ~pend_q;
    busy      = (state_q == RUN) || (state_q == SHOT) || pend_q;
    clk_div   = clk_div_q;
    tick      = tick_q;
    cfg_err   = err_q;
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized scoreboard bench for clk_div_ctrl: a phase-countdown reference model predicts
// the outputs for every cycle, and a monitor compares them one cycle after the edge.
module tb_clk_div_ctrl;

  localparam int W    = 8;
  localparam int DEFD = 7;

  localparam int M_IDLE = 0, M_RUN = 1, M_ARMED = 2, M_SHOT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_div = '0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         start = 1'b0;
  logic         clk_div;
  logic         tick;
  logic         busy;
  logic         cfg_err;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DEFD)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .start    (start),
    .clk_div  (clk_div),
    .tick     (tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: level, mode and cycles left in the current phase.
  int          m_mode;
  bit          m_lvl;
  int unsigned m_left;
  int unsigned m_div;
  bit          m_tick;
  bit          m_pend;
  int unsigned m_pdiv;
  int          m_pmode;
  bit          m_err;

  logic [4:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [4:0] model_outs();
    bit b;
    b = (m_mode == M_RUN) || (m_mode == M_SHOT) || m_pend;
    return {m_lvl, m_tick, b, ~m_pend, m_err};
  endfunction

  function automatic logic [4:0] dut_outs();
    return {clk_div, tick, busy, cfg_ready, cfg_err};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lvl = 0; m_left = 0; m_div = DEFD;
    m_tick = 0; m_pend = 0; m_pdiv = 0; m_pmode = 0; m_err = 0;
  endtask

  task automatic model_enter(input int md, input int unsigned d);
    m_div  = d;
    m_lvl  = 0;
    m_left = d;
    m_mode = (md == 1) ? M_RUN : (md == 2) ? M_ARMED : M_IDLE;
  endtask

  task automatic model_step(input bit cv, input int unsigned d, input int md, input bit st);
    bit xf, lg, had_pend;
    xf       = cv && !m_pend;
    lg       = (d != 0) && (md != 3);
    had_pend = m_pend;
    m_tick   = 0;
    if (xf) m_err = !lg;
    if (m_mode == M_IDLE || m_mode == M_ARMED) begin
      if (m_mode == M_ARMED && st) begin
        m_mode = M_SHOT; m_lvl = 1; m_tick = 1; m_left = m_div;
        if (xf && lg) begin m_pend = 1; m_pdiv = d; m_pmode = md; end
      end else if (xf && lg) begin
        model_enter(md, d);
      end
    end else begin
      if (xf && lg) begin m_pend = 1; m_pdiv = d; m_pmode = md; end
      m_left--;
      if (m_left == 0) begin
        m_tick = 1;
        m_lvl  = !m_lvl;
        m_left = m_div;
        if (!m_lvl) begin
          if (had_pend) begin
            m_pend = 0;
            model_enter(m_pmode, m_pdiv);
          end else if (m_mode == M_SHOT) begin
            m_mode = M_ARMED;
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit cv, input logic [W-1:0] d, input logic [1:0] md, input bit st);
    @(negedge clk);
    cfg_valid = cv; cfg_div = d; cfg_mode = md; start = st;
    model_step(cv, d, md, st);
    sb_q.push_back(model_outs());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, W'($urandom), 2'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cfg_valid = 0; start = 0;
    #2 reset = 0;
    #1 chk("async_reset", dut_outs(), 5'b00010);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  function automatic logic [W-1:0] rand_div();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return '0;
    if (r == 1) return '1;
    if (r < 5)  return W'(1);
    return W'($urandom_range(2, 6));
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) chk("outs", dut_outs(), sb_q.pop_front());
    end
  end

  initial begin
    reset = 1;
    model_reset();
    #1 reset = 0;
    #1 chk("reset_vals", dut_outs(), 5'b00010);
    @(negedge clk);
    reset = 1;

    // RUN div=3, then retune to div=5 during a high phase.
    cycle(1, 3, 2'b01, 0);
    idle(14);
    for (int k = 0; k < 20 && !m_lvl; k++) idle(1);
    cycle(1, 5, 2'b01, 0);
    idle(20);

    // ONESHOT div=4, two identical pulses.
    cycle(1, 4, 2'b10, 0);
    for (int k = 0; k < 40 && m_mode != M_ARMED; k++) idle(1);
    cycle(0, 0, 2'b00, 1);
    idle(8);
    cycle(0, 0, 2'b00, 1);
    idle(8);

    // Illegal configurations, then a legal one clears the error.
    cycle(1, 0, 2'b01, 0);
    idle(2);
    cycle(1, 3, 2'b11, 0);
    idle(2);
    cycle(1, 2, 2'b01, 0);
    idle(6);

    // STOP from RUN div=2.
    cycle(1, 2, 2'b00, 0);
    idle(8);

    // Start and configuration together in ARMED.
    cycle(1, 2, 2'b10, 0);
    cycle(1, 3, 2'b01, 1);
    idle(12);

    // Reset in a high phase with a pending configuration.
    cycle(1, 4, 2'b01, 0);
    for (int k = 0; k < 20 && !m_lvl; k++) idle(1);
    cycle(1, 3, 2'b01, 0);
    idle(1);
    do_reset();
    idle(4);

    // div=1 toggles every cycle; div=255 is the widest half-period.
    cycle(1, 1, 2'b01, 0);
    idle(6);
    cycle(1, 255, 2'b01, 0);
    idle(520);
    cycle(1, 1, 2'b00, 0);
    idle(520);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 5) == 0, rand_div(), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0);
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
